// File: rtl/a8_cmd_fifo.sv
// A8 command-page write filter feeding a small {offset,data} FIFO.
// Optional saturating drop counter: define A8_CMD_DROP_COUNT_EN.
module a8_cmd_fifo #(
   parameter logic [7:0] BASE_PAGE  = 8'hD5,
   parameter int         DEPTH_LOG2 = 4,
   parameter logic [7:0] CTRL_FLUSH = 8'hA5,
   parameter logic [7:0] CTRL_CLRO  = 8'h5A
) (
   input  logic                  clk200,
   input  logic                  a8_rst_n,
   input  logic                  bus_wr_stb,
   input  logic [15:0]           bus_addr,
   input  logic [7:0]            bus_data,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [7:0]            cmd_addr,
   output logic [7:0]            cmd_data,
   output logic [DEPTH_LOG2:0]   fifo_level,
`ifdef A8_CMD_DROP_COUNT_EN
   output logic [7:0]            drop_count,
`endif
   output logic                  overflow
);

   localparam int PW    = DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [15:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] rd_nxt;
   logic [LW-1:0] lvl_after_pop;
   logic [LW-1:0] lvl_nxt;
   logic [15:0]   head_nxt;
   logic [15:0]   entry;
   logic          hit;
   logic          ctrl;
   logic          push_req;
   logic          flush;
   logic          clro;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;

   always_comb begin
      hit      = bus_wr_stb && (bus_addr[15:8] == BASE_PAGE);
      ctrl     = hit && (bus_addr[7:0] == 8'hFF);
      push_req = hit && !ctrl;
      flush    = ctrl && (bus_data == CTRL_FLUSH);
      clro     = ctrl && (bus_data == CTRL_CLRO);
      full     = (fifo_level == FULL_LVL);
      pop      = cmd_valid && cmd_ready;
      push     = push_req && (!full || pop);
      drop     = push_req && full && !pop;
      entry    = {bus_addr[7:0], bus_data};
      rd_nxt   = rd_ptr + PW'(pop);
      lvl_after_pop = fifo_level - LW'(pop);
      lvl_nxt  = lvl_after_pop + LW'(push);
   end

   // The head register is loaded directly from the bus when the
   // entry lands in an otherwise empty FIFO; no same-cycle fall-through.
   always_comb begin
      head_nxt = '0;
      if (lvl_after_pop == '0) begin
         if (push)
            head_nxt = entry;
      end else begin
         head_nxt = mem[rd_nxt];
      end
   end

   always_ff @(posedge clk200) begin
      if (push)
         mem[wr_ptr] <= entry;
   end

   always_ff @(posedge clk200 or negedge a8_rst_n) begin
      if (!a8_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         cmd_valid  <= 1'b0;
         cmd_addr   <= 8'h00;
         cmd_data   <= 8'h00;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         cmd_valid  <= 1'b0;
         cmd_addr   <= 8'h00;
         cmd_data   <= 8'h00;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         rd_ptr     <= rd_nxt;
         fifo_level <= lvl_nxt;
         cmd_valid  <= (lvl_nxt != '0);
         cmd_addr   <= head_nxt[15:8];
         cmd_data   <= head_nxt[7:0];
      end
   end

   always_ff @(posedge clk200 or negedge a8_rst_n) begin
      if (!a8_rst_n)
         overflow <= 1'b0;
      else if (clro)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
   end

`ifdef A8_CMD_DROP_COUNT_EN
   always_ff @(posedge clk200 or negedge a8_rst_n) begin
      if (!a8_rst_n)
         drop_count <= 8'h00;
      else if (clro)
         drop_count <= 8'h00;
      else if (drop && (drop_count != 8'hFF))
         drop_count <= drop_count + 8'h01;
   end
`endif

endmodule

// File: tb/tb_a8_cmd_fifo.sv
// Directed self-checking bench for a8_cmd_fifo.
// Drop-counter checks compile in with A8_CMD_DROP_COUNT_EN.
`timescale 1ns/1ps
module tb_a8_cmd_fifo;

   logic        clk200 = 1'b0;
   logic        a8_rst_n = 1'b0;
   logic        bus_wr_stb = 1'b0;
   logic [15:0] bus_addr = '0;
   logic [7:0]  bus_data = '0;
   logic        cmd_ready = 1'b0;
   logic        cmd_valid;
   logic [7:0]  cmd_addr;
   logic [7:0]  cmd_data;
   logic [4:0]  fifo_level;
   logic        overflow;
`ifdef A8_CMD_DROP_COUNT_EN
   logic [7:0]  drop_count;
`endif

   int checks = 0;
   int errors = 0;

   a8_cmd_fifo dut (
      .clk200     (clk200),
      .a8_rst_n   (a8_rst_n),
      .bus_wr_stb (bus_wr_stb),
      .bus_addr   (bus_addr),
      .bus_data   (bus_data),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .fifo_level (fifo_level),
`ifdef A8_CMD_DROP_COUNT_EN
      .drop_count (drop_count),
`endif
      .overflow   (overflow)
   );

   always #2.5 clk200 = ~clk200;

   task automatic tick();
      @(posedge clk200);
      #1;
   endtask

   task automatic strobe(input logic [15:0] a, input logic [7:0] d);
      bus_wr_stb = 1'b1;
      bus_addr   = a;
      bus_data   = d;
      tick();
      bus_wr_stb = 1'b0;
   endtask

   task automatic test_reset();
      a8_rst_n = 1'b0;
      #1;
      checks++;
      if ({fifo_level, cmd_valid, overflow, cmd_addr, cmd_data} !== 23'd0) begin
         errors++;
         $display("FAIL reset: lvl=%0d v=%b ovf=%b a=%h d=%h, want all 0",
                  fifo_level, cmd_valid, overflow, cmd_addr, cmd_data);
      end
      tick();
      a8_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_push();
      cmd_ready = 1'b0;
      strobe(16'hD510, 8'h3C);
      checks++;
      if ({cmd_valid, cmd_addr, cmd_data, fifo_level} !== {1'b1, 8'h10, 8'h3C, 5'd1}) begin
         errors++;
         $display("FAIL basic_push: v=%b a=%h d=%h lvl=%0d, want 1 10 3c 1",
                  cmd_valid, cmd_addr, cmd_data, fifo_level);
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      checks++;
      if ({cmd_valid, fifo_level} !== {1'b0, 5'd0}) begin
         errors++;
         $display("FAIL basic_pop: v=%b lvl=%0d, want 0 0", cmd_valid, fifo_level);
      end
   endtask

   task automatic test_addr_filter();
      strobe(16'hD410, 8'h01);
      strobe(16'hD610, 8'h02);
      strobe(16'h0510, 8'h03);
      bus_addr = 16'hD511;
      tick();
      checks++;
      if ({cmd_valid, fifo_level} !== {1'b0, 5'd0}) begin
         errors++;
         $display("FAIL addr_filter: v=%b lvl=%0d, want 0 0", cmd_valid, fifo_level);
      end
   endtask

   task automatic fill16(input logic [7:0] base);
      for (int i = 0; i < 16; i++)
         strobe({8'hD5, base + 8'(i)}, base + 8'(i));
   endtask

   task automatic test_fill_overflow();
      fill16(8'h00);
      checks++;
      if ({fifo_level, overflow} !== {5'd16, 1'b0}) begin
         errors++;
         $display("FAIL fill16: lvl=%0d ovf=%b, want 16 0", fifo_level, overflow);
      end
      strobe(16'hD520, 8'h20);
      checks++;
      if ({fifo_level, overflow} !== {5'd16, 1'b1}) begin
         errors++;
         $display("FAIL overflow: lvl=%0d ovf=%b, want 16 1", fifo_level, overflow);
      end
      cmd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({cmd_valid, cmd_addr, cmd_data} !== {1'b1, 8'(i), 8'(i)}) begin
            errors++;
            $display("FAIL drain[%0d]: v=%b a=%h d=%h, want 1 %h %h",
                     i, cmd_valid, cmd_addr, cmd_data, i[7:0], i[7:0]);
         end
         tick();
      end
      cmd_ready = 1'b0;
      checks++;
      if ({cmd_valid, fifo_level} !== {1'b0, 5'd0}) begin
         errors++;
         $display("FAIL drain_empty: v=%b lvl=%0d, want 0 0", cmd_valid, fifo_level);
      end
   endtask

   task automatic test_full_pop();
      strobe(16'hD5FF, 8'h5A);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL clro_pre: ovf=%b, want 0", overflow);
      end
      fill16(8'h00);
      cmd_ready = 1'b1;
      strobe(16'hD530, 8'h30);
      checks++;
      if ({fifo_level, overflow, cmd_addr} !== {5'd16, 1'b0, 8'h01}) begin
         errors++;
         $display("FAIL full_pop: lvl=%0d ovf=%b a=%h, want 16 0 01",
                  fifo_level, overflow, cmd_addr);
      end
      for (int i = 1; i < 16; i++) begin
         checks++;
         if (cmd_addr !== 8'(i)) begin
            errors++;
            $display("FAIL full_pop_drain[%0d]: a=%h, want %h", i, cmd_addr, i[7:0]);
         end
         tick();
      end
      checks++;
      if ({cmd_valid, cmd_addr, cmd_data} !== {1'b1, 8'h30, 8'h30}) begin
         errors++;
         $display("FAIL full_pop_last: v=%b a=%h d=%h, want 1 30 30",
                  cmd_valid, cmd_addr, cmd_data);
      end
      tick();
      cmd_ready = 1'b0;
      checks++;
      if ({cmd_valid, fifo_level} !== {1'b0, 5'd0}) begin
         errors++;
         $display("FAIL full_pop_empty: v=%b lvl=%0d, want 0 0", cmd_valid, fifo_level);
      end
   endtask

   task automatic test_ctrl();
      for (int i = 0; i < 5; i++)
         strobe({8'hD5, 8'h40 + 8'(i)}, 8'h70 + 8'(i));
      checks++;
      if (fifo_level !== 5'd5) begin
         errors++;
         $display("FAIL ctrl_fill5: lvl=%0d, want 5", fifo_level);
      end
      strobe(16'hD5FF, 8'hA5);
      checks++;
      if ({cmd_valid, fifo_level} !== {1'b0, 5'd0}) begin
         errors++;
         $display("FAIL flush: v=%b lvl=%0d, want 0 0", cmd_valid, fifo_level);
      end
      fill16(8'h80);
      strobe(16'hD5A0, 8'hEE);
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ctrl_ovf: ovf=%b, want 1", overflow);
      end
      strobe(16'hD5FF, 8'h5A);
      checks++;
      if ({overflow, fifo_level} !== {1'b0, 5'd16}) begin
         errors++;
         $display("FAIL clro: ovf=%b lvl=%0d, want 0 16", overflow, fifo_level);
      end
      strobe(16'hD5FF, 8'h11);
      checks++;
      if ({overflow, fifo_level, cmd_valid, cmd_addr, cmd_data} !==
          {1'b0, 5'd16, 1'b1, 8'h80, 8'h80}) begin
         errors++;
         $display("FAIL ctrl_other: ovf=%b lvl=%0d v=%b a=%h d=%h, want 0 16 1 80 80",
                  overflow, fifo_level, cmd_valid, cmd_addr, cmd_data);
      end
      cmd_ready = 1'b1;
      strobe(16'hD5FF, 8'hA5);
      cmd_ready = 1'b0;
      checks++;
      if ({cmd_valid, fifo_level} !== {1'b0, 5'd0}) begin
         errors++;
         $display("FAIL flush_pop: v=%b lvl=%0d, want 0 0", cmd_valid, fifo_level);
      end
   endtask

   task automatic test_reset_wrap();
      for (int i = 0; i < 10; i++)
         strobe({8'hD5, 8'h40 + 8'(i)}, 8'(i));
      cmd_ready = 1'b1;
      repeat (10) tick();
      cmd_ready = 1'b0;
      for (int i = 0; i < 12; i++)
         strobe({8'hD5, 8'h60 + 8'(i)}, 8'hC0 + 8'(i));
      checks++;
      if ({fifo_level, cmd_addr, cmd_data} !== {5'd12, 8'h60, 8'hC0}) begin
         errors++;
         $display("FAIL wrap_fill: lvl=%0d a=%h d=%h, want 12 60 c0",
                  fifo_level, cmd_addr, cmd_data);
      end
      cmd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({cmd_addr, cmd_data} !== {8'h60 + 8'(i), 8'hC0 + 8'(i)}) begin
            errors++;
            $display("FAIL wrap_drain[%0d]: a=%h d=%h", i, cmd_addr, cmd_data);
         end
         tick();
      end
      a8_rst_n = 1'b0;
      #1;
      checks++;
      if ({fifo_level, cmd_valid, overflow, cmd_addr, cmd_data} !== 23'd0) begin
         errors++;
         $display("FAIL async_reset: lvl=%0d v=%b ovf=%b a=%h d=%h, want all 0",
                  fifo_level, cmd_valid, overflow, cmd_addr, cmd_data);
      end
      cmd_ready = 1'b0;
      tick();
      a8_rst_n = 1'b1;
      tick();
      strobe(16'hD577, 8'h99);
      checks++;
      if ({fifo_level, cmd_valid, cmd_addr, cmd_data} !== {5'd1, 1'b1, 8'h77, 8'h99}) begin
         errors++;
         $display("FAIL post_reset: lvl=%0d v=%b a=%h d=%h, want 1 1 77 99",
                  fifo_level, cmd_valid, cmd_addr, cmd_data);
      end
   endtask

`ifdef A8_CMD_DROP_COUNT_EN
   task automatic test_drop_count();
      strobe(16'hD5FF, 8'hA5);
      fill16(8'h00);
      for (int i = 0; i < 300; i++)
         strobe(16'hD5B0, 8'(i));
      checks++;
      if ({drop_count, overflow} !== {8'hFF, 1'b1}) begin
         errors++;
         $display("FAIL drop_sat: cnt=%h ovf=%b, want ff 1", drop_count, overflow);
      end
      strobe(16'hD5FF, 8'h5A);
      checks++;
      if ({drop_count, overflow} !== {8'h00, 1'b0}) begin
         errors++;
         $display("FAIL drop_clr: cnt=%h ovf=%b, want 00 0", drop_count, overflow);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_push();
      test_addr_filter();
      test_fill_overflow();
      test_full_pop();
      test_ctrl();
      test_reset_wrap();
`ifdef A8_CMD_DROP_COUNT_EN
      test_drop_count();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/a8_cmd_fifo.md
Name: a8_cmd_fifo

Overview:
- Sits directly downstream of bus_a8, in the clk200 domain.
- Consumes bus_a8's qualified A8 write strobes and keeps only writes to a single command page (default $D5xx, the cartridge CCTL area).
- Buffers accepted writes as {offset, data} entries in a small FIFO, presented to the pixel/command engine over a valid/ready interface.
- Offset $FF of the page is a control register used to flush the FIFO and clear the overflow flag.

Parameters:
- BASE_PAGE, 8'hD5, high address byte that selects the command page.
- DEPTH_LOG2, 4, log2 of the FIFO depth (default 16 entries).
- CTRL_FLUSH, 8'hA5, data value that flushes the FIFO when written to offset $FF.
- CTRL_CLRO, 8'h5A, data value that clears the overflow flag when written to offset $FF.

Ports:
- clk200  input  1  200 MHz FPGA clock; all logic is on the rising edge.
- a8_rst_n  input  1  asynchronous, active-low reset.
- bus_wr_stb  input  1  one-cycle pulse from bus_a8, one per completed A8 write cycle.
- bus_addr  input  16  A8 address, valid while bus_wr_stb is high.
- bus_data  input  8  A8 write data, valid while bus_wr_stb is high.
- cmd_valid  output  1  FIFO head entry is valid.
- cmd_ready  input  1  consumer accepts the head entry.
- cmd_addr  output  8  head entry: low address byte (page offset).
- cmd_data  output  8  head entry: data byte.
- fifo_level  output  DEPTH_LOG2+1  current number of stored entries, 0..2^DEPTH_LOG2.
- overflow  output  1  sticky flag: a push was dropped because the FIFO was full.

Behaviour:
- Clock and reset: single clock clk200; a8_rst_n is asynchronous and active-low.
- Reset values:
  - read and write pointers = 0.
  - fifo_level = 0, cmd_valid = 0, overflow = 0.
  - cmd_addr and cmd_data = 8'h00.
  - Storage array contents are not reset.
- Decode (combinational, only when bus_wr_stb=1):
  - hit = (bus_addr[15:8] == BASE_PAGE).
  - ctrl = hit && bus_addr[7:0] == 8'hFF.
  - push_req = hit && !ctrl.
- Control writes (ctrl asserted):
  - bus_data == CTRL_FLUSH: next cycle both pointers = 0, fifo_level = 0, cmd_valid = 0. overflow is unchanged.
  - bus_data == CTRL_CLRO: overflow <= 0.
  - Any other value: ignored.
  - Control writes are never stored in the FIFO.
- Push:
  - Condition: push_req && (fifo_level < 2^DEPTH_LOG2 || pop).
  - Action: write {bus_addr[7:0], bus_data} at wr_ptr, then wr_ptr++.
- Pop:
  - Condition: cmd_valid && cmd_ready.
  - Action: rd_ptr++.
- Level update:
  - fifo_level += push - pop.
  - Pointers are DEPTH_LOG2 bits wide and wrap modulo the depth.
- Outputs:
  - cmd_valid = (fifo_level != 0).
  - cmd_addr/cmd_data are the head entry, stable while cmd_valid && !cmd_ready.
  - No fall-through: with an empty FIFO, a strobe at cycle N gives cmd_valid=1 at N+1 at the earliest.
- Full FIFO:
  - push_req with no pop in the same cycle: entry dropped, overflow <= 1, pointers and level unchanged.
  - push_req with a pop in the same cycle: the push is accepted and fifo_level stays at full.
- Empty FIFO: cmd_ready is ignored; there is no underflow and no pointer movement.
- Flush with a same-cycle pop: the pop handshake completes (the consumer took the data), then the flush result applies; the FIFO is empty the next cycle.
- Flush and overflow in the same cycle: not possible, since a strobe is either ctrl or push_req.
- Non-matching addresses and bus_wr_stb=0: no state change.
- Reset mid-operation: all pointers, flags and outputs return to their reset values immediately (asynchronously). Entries in flight are lost and no handshake completes.

Optional Feature:
- Macro: A8_CMD_DROP_COUNT_EN.
- When defined:
  - Adds output drop_count [7:0], reset value 0.
  - drop_count increments by 1 for every dropped push and saturates at 8'hFF.
  - A CTRL_CLRO write clears drop_count together with overflow.
- When undefined:
  - The port and counter do not exist.
  - overflow behaviour is unchanged.

Test Plan:
- Basic push: strobe addr $D510, data $3C, cmd_ready=0.
  - Next cycle: cmd_valid=1, cmd_addr=$10, cmd_data=$3C, fifo_level=1.
  - Then raise cmd_ready for 1 cycle: fifo_level=0, cmd_valid=0.
- Address filter: strobes to $D410, $D610 and $0510.
  - fifo_level stays 0 and cmd_valid stays 0.
- Fill and overflow: 16 strobes to $D500..$D50F with data=offset, then a 17th to $D520.
  - fifo_level=16, overflow=1.
  - Draining yields offsets $00..$0F in order; $20 never appears.
- Full with simultaneous pop: with the FIFO full, assert cmd_ready in the same cycle as a strobe to $D530.
  - fifo_level stays 16, overflow stays 0, $30 is the last entry drained.
- Control writes: fill 5 entries, then:
  - Write $A5 to $D5FF: the next cycle fifo_level=0 and cmd_valid=0.
  - Overflow the FIFO, write $5A to $D5FF: overflow=0.
  - Write $11 to $D5FF: no change in state.
- Reset and wrap: push 10 and pop 10 entries, then push 12 (pointer wrap); assert a8_rst_n=0 mid-drain.
  - Outputs go to 0 asynchronously.
  - After release, a fresh push appears with fifo_level=1.
  - With A8_CMD_DROP_COUNT_EN, 300 dropped pushes give drop_count=$FF.
